// File: rtl/dual_port_arb_ram.sv
// Single-port word array shared by two valid/ready channels with round-robin
// arbitration and held responses. Define RAM_ADDR_ERR_EN for out-of-range error responses.
module dual_port_arb_ram #(
    parameter int DW    = 32,
    parameter int MW    = DW / 8,
    parameter int AW    = 32,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req_vld,
    output logic          a_req_rdy,
    input  logic [AW-1:0] a_req_addr,
    input  logic          a_req_we,
    input  logic [MW-1:0] a_req_wem,
    input  logic [DW-1:0] a_req_wdata,
    output logic          a_rsp_vld,
    input  logic          a_rsp_rdy,
    output logic [DW-1:0] a_rsp_rdata,
    input  logic          b_req_vld,
    output logic          b_req_rdy,
    input  logic [AW-1:0] b_req_addr,
    input  logic          b_req_we,
    input  logic [MW-1:0] b_req_wem,
    input  logic [DW-1:0] b_req_wdata,
    output logic          b_rsp_vld,
    input  logic          b_rsp_rdy,
    output logic [DW-1:0] b_rsp_rdata
`ifdef RAM_ADDR_ERR_EN
    ,
    output logic          a_rsp_err,
    output logic          b_rsp_err
`endif
);

    localparam int LSB = $clog2(MW);
    localparam int IW  = $clog2(DEPTH);
    localparam int FW  = AW - LSB;

    logic [DW-1:0] mem [DEPTH];

    logic          a_elig_s, b_elig_s, a_gnt_s, b_gnt_s;
    logic [AW-1:0] acc_addr_s;
    logic          acc_we_s;
    logic [MW-1:0] acc_wem_s;
    logic [DW-1:0] acc_wdata_s;
    logic [FW-1:0] acc_word_s;
    logic [IW-1:0] acc_idx_s;
    logic          acc_oor_s;
    logic [DW-1:0] rsp_data_s;
    logic          wr_en_s;
    logic          unused_s;

    logic          last_b_q, last_b_d;
    logic          a_rsp_vld_q, a_rsp_vld_d, b_rsp_vld_q, b_rsp_vld_d;
    logic [DW-1:0] a_rsp_rdata_q, a_rsp_rdata_d, b_rsp_rdata_q, b_rsp_rdata_d;
    logic          a_rsp_err_q, a_rsp_err_d, b_rsp_err_q, b_rsp_err_d;

    // Eligibility and round-robin grant; last_b_q=1 means B won most recently.
    always_comb begin
        a_elig_s = a_req_vld & (~a_rsp_vld_q | a_rsp_rdy) & ~rst;
        b_elig_s = b_req_vld & (~b_rsp_vld_q | b_rsp_rdy) & ~rst;
        if (a_elig_s & b_elig_s) begin
            a_gnt_s = last_b_q;
            b_gnt_s = ~last_b_q;
        end else begin
            a_gnt_s = a_elig_s;
            b_gnt_s = b_elig_s;
        end
    end

    // Shared array access driven by whichever channel holds the grant.
    always_comb begin
        acc_addr_s  = b_gnt_s ? b_req_addr  : a_req_addr;
        acc_we_s    = b_gnt_s ? b_req_we    : a_req_we;
        acc_wem_s   = b_gnt_s ? b_req_wem   : a_req_wem;
        acc_wdata_s = b_gnt_s ? b_req_wdata : a_req_wdata;
        acc_word_s  = acc_addr_s[AW-1:LSB];
        acc_idx_s   = acc_word_s[IW-1:0];
`ifdef RAM_ADDR_ERR_EN
        acc_oor_s   = (acc_word_s >> IW) != {FW{1'b0}};
`else
        acc_oor_s   = 1'b0;
`endif
        rsp_data_s  = (acc_we_s | acc_oor_s) ? {DW{1'b0}} : mem[acc_idx_s];
        wr_en_s     = (a_gnt_s | b_gnt_s) & acc_we_s & ~acc_oor_s;
    end

    // Response and arbitration-pointer next state.
    always_comb begin
        a_rsp_vld_d   = a_rsp_vld_q;
        a_rsp_rdata_d = a_rsp_rdata_q;
        a_rsp_err_d   = a_rsp_err_q;
        b_rsp_vld_d   = b_rsp_vld_q;
        b_rsp_rdata_d = b_rsp_rdata_q;
        b_rsp_err_d   = b_rsp_err_q;
        last_b_d      = last_b_q;
        if (a_gnt_s) begin
            a_rsp_vld_d   = 1'b1;
            a_rsp_rdata_d = rsp_data_s;
            a_rsp_err_d   = acc_oor_s;
            last_b_d      = 1'b0;
        end else if (a_rsp_rdy) begin
            a_rsp_vld_d   = 1'b0;
        end else begin
            a_rsp_vld_d   = a_rsp_vld_q;
        end
        if (b_gnt_s) begin
            b_rsp_vld_d   = 1'b1;
            b_rsp_rdata_d = rsp_data_s;
            b_rsp_err_d   = acc_oor_s;
            last_b_d      = 1'b1;
        end else if (b_rsp_rdy) begin
            b_rsp_vld_d   = 1'b0;
        end else begin
            b_rsp_vld_d   = b_rsp_vld_q;
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b_q      <= 1'b1;
            a_rsp_vld_q   <= 1'b0;
            a_rsp_rdata_q <= {DW{1'b0}};
            a_rsp_err_q   <= 1'b0;
            b_rsp_vld_q   <= 1'b0;
            b_rsp_rdata_q <= {DW{1'b0}};
            b_rsp_err_q   <= 1'b0;
        end else begin
            last_b_q      <= last_b_d;
            a_rsp_vld_q   <= a_rsp_vld_d;
            a_rsp_rdata_q <= a_rsp_rdata_d;
            a_rsp_err_q   <= a_rsp_err_d;
            b_rsp_vld_q   <= b_rsp_vld_d;
            b_rsp_rdata_q <= b_rsp_rdata_d;
            b_rsp_err_q   <= b_rsp_err_d;
        end
    end

    // Byte-masked array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < MW; i++) begin
                if (acc_wem_s[i]) begin
                    mem[acc_idx_s][i*8 +: 8] <= acc_wdata_s[i*8 +: 8];
                end
            end
        end
    end

    assign a_req_rdy   = a_gnt_s;
    assign b_req_rdy   = b_gnt_s;
    assign a_rsp_vld   = a_rsp_vld_q;
    assign a_rsp_rdata = a_rsp_rdata_q;
    assign b_rsp_vld   = b_rsp_vld_q;
    assign b_rsp_rdata = b_rsp_rdata_q;
`ifdef RAM_ADDR_ERR_EN
    assign a_rsp_err   = a_rsp_err_q;
    assign b_rsp_err   = b_rsp_err_q;
    assign unused_s    = ^{acc_addr_s[LSB-1:0]};
`else
    assign unused_s    = ^{acc_addr_s[LSB-1:0], acc_word_s[FW-1:IW], a_rsp_err_q, b_rsp_err_q};
`endif

endmodule

// File: tb/tb_dual_port_arb_ram.sv
// Self-checking bench for dual_port_arb_ram: directed vector table, corner-case
// sequences and randomized traffic against a word-array reference model.
module tb_dual_port_arb_ram;

    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int AW    = 32;
    localparam int DEPTH = 4096;
`ifdef RAM_ADDR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_req_vld, a_req_rdy, a_req_we, a_rsp_vld, a_rsp_rdy;
    logic [AW-1:0] a_req_addr;
    logic [MW-1:0] a_req_wem;
    logic [DW-1:0] a_req_wdata, a_rsp_rdata;
    logic          b_req_vld, b_req_rdy, b_req_we, b_rsp_vld, b_rsp_rdy;
    logic [AW-1:0] b_req_addr;
    logic [MW-1:0] b_req_wem;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;
    logic          a_rsp_err, b_rsp_err;

    dual_port_arb_ram #(.DW(DW), .MW(MW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req_vld(a_req_vld), .a_req_rdy(a_req_rdy), .a_req_addr(a_req_addr),
        .a_req_we(a_req_we), .a_req_wem(a_req_wem), .a_req_wdata(a_req_wdata),
        .a_rsp_vld(a_rsp_vld), .a_rsp_rdy(a_rsp_rdy), .a_rsp_rdata(a_rsp_rdata),
        .b_req_vld(b_req_vld), .b_req_rdy(b_req_rdy), .b_req_addr(b_req_addr),
        .b_req_we(b_req_we), .b_req_wem(b_req_wem), .b_req_wdata(b_req_wdata),
        .b_rsp_vld(b_rsp_vld), .b_rsp_rdy(b_rsp_rdy), .b_rsp_rdata(b_rsp_rdata)
`ifdef RAM_ADDR_ERR_EN
        , .a_rsp_err(a_rsp_err), .b_rsp_err(b_rsp_err)
`endif
    );
`ifndef RAM_ADDR_ERR_EN
    assign a_rsp_err = 1'b0;
    assign b_rsp_err = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        a_vld, a_we, a_rrdy;
        logic [31:0] a_addr;
        logic [3:0]  a_wem;
        logic [31:0] a_wdata;
        logic        b_vld, b_we, b_rrdy;
        logic [31:0] b_addr;
        logic [3:0]  b_wem;
        logic [31:0] b_wdata;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          a_chk;
        logic [31:0] a_exp;
        bit          b_chk;
        logic [31:0] b_exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model: word store plus per-channel pending response.
    logic [31:0] mm [int];
    bit          m_a_vld, m_b_vld, m_a_err, m_b_err;
    logic [31:0] m_a_data, m_b_data;
    bit          m_last_b;
    logic        dut_ga, dut_gb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_access(input logic we, input logic [31:0] addr, input logic [3:0] wem,
                                input logic [31:0] wdata, output logic [31:0] data, output bit err);
        int unsigned word = addr / 32'd4;
        int          idx  = int'(word % DEPTH);
        logic [31:0] cur;
        err = ERR_EN && (word >= DEPTH);
        cur = mm.exists(idx) ? mm[idx] : 32'h0;
        data = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < 4; i++) if (wem[i]) cur[i*8 +: 8] = wdata[i*8 +: 8];
                mm[idx] = cur;
            end else begin
                data = cur;
            end
        end
    endtask

    task automatic cycle(input stim_t s);
        bit ea, eb, ga, gb;
        logic [31:0] d;
        bit e;
        rst = s.rst;
        a_req_vld = s.a_vld; a_req_we = s.a_we; a_req_addr = s.a_addr;
        a_req_wem = s.a_wem; a_req_wdata = s.a_wdata; a_rsp_rdy = s.a_rrdy;
        b_req_vld = s.b_vld; b_req_we = s.b_we; b_req_addr = s.b_addr;
        b_req_wem = s.b_wem; b_req_wdata = s.b_wdata; b_rsp_rdy = s.b_rrdy;
        #1;
        ea = !s.rst && s.a_vld && (!m_a_vld || s.a_rrdy);
        eb = !s.rst && s.b_vld && (!m_b_vld || s.b_rrdy);
        ga = ea && (!eb || m_last_b);
        gb = eb && !ga;
        dut_ga = a_req_rdy;
        dut_gb = b_req_rdy;
        chk("a_req_rdy", {31'd0, a_req_rdy}, {31'd0, ga});
        chk("b_req_rdy", {31'd0, b_req_rdy}, {31'd0, gb});
        @(posedge clk);
        if (s.rst) begin
            m_a_vld = 1'b0; m_b_vld = 1'b0; m_last_b = 1'b1;
        end else begin
            if (ga) begin
                model_access(s.a_we, s.a_addr, s.a_wem, s.a_wdata, d, e);
                m_a_vld = 1'b1; m_a_data = d; m_a_err = e; m_last_b = 1'b0;
            end else if (s.a_rrdy) m_a_vld = 1'b0;
            if (gb) begin
                model_access(s.b_we, s.b_addr, s.b_wem, s.b_wdata, d, e);
                m_b_vld = 1'b1; m_b_data = d; m_b_err = e; m_last_b = 1'b1;
            end else if (s.b_rrdy) m_b_vld = 1'b0;
        end
        #1;
        chk("a_rsp_vld", {31'd0, a_rsp_vld}, {31'd0, m_a_vld});
        chk("b_rsp_vld", {31'd0, b_rsp_vld}, {31'd0, m_b_vld});
        if (m_a_vld) begin
            chk("a_rsp_rdata", a_rsp_rdata, m_a_data);
            if (ERR_EN) chk("a_rsp_err", {31'd0, a_rsp_err}, {31'd0, m_a_err});
        end
        if (m_b_vld) begin
            chk("b_rsp_rdata", b_rsp_rdata, m_b_data);
            if (ERR_EN) chk("b_rsp_err", {31'd0, b_rsp_err}, {31'd0, m_b_err});
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0;
        s.a_vld = 1'b0; s.a_we = 1'b0; s.a_rrdy = 1'b1; s.a_addr = 32'h0; s.a_wem = 4'h0; s.a_wdata = 32'h0;
        s.b_vld = 1'b0; s.b_we = 1'b0; s.b_rrdy = 1'b1; s.b_addr = 32'h0; s.b_wem = 4'h0; s.b_wdata = 32'h0;
        return s;
    endfunction

    function automatic stim_t rd_a(input logic [31:0] addr);
        stim_t s = idle();
        s.a_vld = 1'b1; s.a_addr = addr;
        return s;
    endfunction

    function automatic stim_t wr_b(input logic [31:0] addr, input logic [3:0] wem, input logic [31:0] data);
        stim_t s = idle();
        s.b_vld = 1'b1; s.b_we = 1'b1; s.b_addr = addr; s.b_wem = wem; s.b_wdata = data;
        return s;
    endfunction

    function automatic vec_t mk(input stim_t s, input bit ac, input logic [31:0] ae,
                                input bit bc, input logic [31:0] be);
        vec_t v;
        v.s = s; v.a_chk = ac; v.a_exp = ae; v.b_chk = bc; v.b_exp = be;
        return v;
    endfunction

    vec_t        tbl[$];
    stim_t       s;
    logic [31:0] held;

    initial begin
        m_a_vld = 1'b0; m_b_vld = 1'b0; m_last_b = 1'b1;
        m_a_data = 32'h0; m_b_data = 32'h0; m_a_err = 1'b0; m_b_err = 1'b0;

        s = idle(); s.rst = 1'b1;
        cycle(s);
        cycle(s);
        chk("reset_a_rdata", a_rsp_rdata, 32'h0);
        chk("reset_b_rdata", b_rsp_rdata, 32'h0);

        tbl.push_back(mk(wr_b(32'h10, 4'hF, 32'hDEADBEEF), 1'b0, 32'h0, 1'b1, 32'h0));
        tbl.push_back(mk(rd_a(32'h10), 1'b1, 32'hDEADBEEF, 1'b0, 32'h0));
        tbl.push_back(mk(wr_b(32'h10, 4'b0001, 32'h000000AA), 1'b0, 32'h0, 1'b1, 32'h0));
        tbl.push_back(mk(rd_a(32'h13), 1'b1, 32'hDEADBEAA, 1'b0, 32'h0));
        tbl.push_back(mk(wr_b(32'h20, 4'hF, 32'h12345678), 1'b0, 32'h0, 1'b1, 32'h0));
        tbl.push_back(mk(wr_b(32'h20, 4'h0, 32'h0), 1'b0, 32'h0, 1'b1, 32'h0));
        tbl.push_back(mk(rd_a(32'h20), 1'b1, 32'h12345678, 1'b0, 32'h0));
        tbl.push_back(mk(rd_a(32'h4010), 1'b1, ERR_EN ? 32'h0 : 32'hDEADBEAA, 1'b0, 32'h0));
        tbl.push_back(mk(wr_b(32'h4010, 4'hF, 32'hFFFFFFFF), 1'b0, 32'h0, 1'b1, 32'h0));
        tbl.push_back(mk(rd_a(32'h10), 1'b1, ERR_EN ? 32'hDEADBEAA : 32'hFFFFFFFF, 1'b0, 32'h0));
        tbl.push_back(mk(wr_b(32'h10, 4'hF, 32'hDEADBEAA), 1'b0, 32'h0, 1'b1, 32'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].s);
            if (tbl[i].a_chk) chk($sformatf("tbl%0d_a", i), a_rsp_rdata, tbl[i].a_exp);
            if (tbl[i].b_chk) chk($sformatf("tbl%0d_b", i), b_rsp_rdata, tbl[i].b_exp);
        end

        // Alternation from reset state: A first, then strict A/B/A/B.
        s = idle(); s.rst = 1'b1;
        cycle(s);
        for (int i = 0; i < 8; i++) begin
            s = rd_a(32'h10); s.b_vld = 1'b1; s.b_addr = 32'h20;
            cycle(s);
            chk("alt_a_gnt", {31'd0, dut_ga}, {31'd0, (i % 2) == 0});
            chk("alt_b_gnt", {31'd0, dut_gb}, {31'd0, (i % 2) == 1});
        end
        cycle(idle());

        // A response stalled for three cycles while B streams.
        cycle(rd_a(32'h10));
        held = a_rsp_rdata;
        for (int i = 0; i < 3; i++) begin
            s = rd_a(32'h20); s.a_rrdy = 1'b0; s.b_vld = 1'b1; s.b_addr = 32'h20;
            cycle(s);
            chk("stall_a_rdy", {31'd0, dut_ga}, 32'd0);
            chk("stall_b_rdy", {31'd0, dut_gb}, 32'd1);
            chk("stall_a_vld", {31'd0, a_rsp_vld}, 32'd1);
            chk("stall_a_hold", a_rsp_rdata, held);
        end
        cycle(idle());

        // Reset with a pending A response and a B write in the reset cycle.
        s = rd_a(32'h10); s.a_rrdy = 1'b0;
        cycle(s);
        s = wr_b(32'h20, 4'hF, 32'hCAFEF00D); s.rst = 1'b1; s.a_vld = 1'b1; s.a_rrdy = 1'b0;
        cycle(s);
        chk("rst_a_vld", {31'd0, a_rsp_vld}, 32'd0);
        chk("rst_b_vld", {31'd0, b_rsp_vld}, 32'd0);
        s = rd_a(32'h20); s.b_vld = 1'b1; s.b_addr = 32'h20;
        cycle(s);
        chk("rst_ptr_a", {31'd0, dut_ga}, 32'd1);
        chk("rst_nowrite", a_rsp_rdata, 32'h12345678);
        cycle(s);
        chk("rst_ptr_b", {31'd0, dut_gb}, 32'd1);
        chk("rst_nowrite_b", b_rsp_rdata, 32'h12345678);
        cycle(idle());

        for (int w = 0; w < 16; w++) cycle(wr_b(32'(w * 4), 4'hF, $urandom));

        for (int n = 0; n < 400; n++) begin
            int unsigned ka, kb;
            ka = ERR_EN ? (($urandom_range(0, 7) == 0) ? 1 : 0) : $urandom_range(0, 3);
            kb = ERR_EN ? (($urandom_range(0, 7) == 0) ? 1 : 0) : $urandom_range(0, 3);
            s.rst     = ($urandom_range(0, 63) == 0);
            s.a_vld   = ($urandom_range(0, 3) != 0);
            s.a_we    = $urandom_range(0, 1);
            s.a_addr  = 32'(ka * DEPTH * 4 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            s.a_wem   = 4'($urandom);
            s.a_wdata = $urandom;
            s.a_rrdy  = ($urandom_range(0, 3) != 0);
            s.b_vld   = ($urandom_range(0, 3) != 0);
            s.b_we    = $urandom_range(0, 1);
            s.b_addr  = 32'(kb * DEPTH * 4 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            s.b_wem   = 4'($urandom);
            s.b_wdata = $urandom;
            s.b_rrdy  = ($urandom_range(0, 3) != 0);
            cycle(s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
